// File: rtl/vehicle_counter.sv
// vehicle_counter: per-road debounced vehicle counter with BCD snapshots.
// Each road has a 2-flop synchroniser, a debounce counter and an edge
// detector that produces one event per vehicle. Events accumulate in a
// saturating two-digit BCD counter. Every toggle of the timer's phase flag
// latches both counts (floored to MIN_COUNT) into the outputs and restarts
// the live counters.
module vehicle_counter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_COUNT       = 1
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       sensor1,
    input  logic       sensor2,
    input  logic       phase,
    output logic [3:0] count1Hi,
    output logic [3:0] count1Lo,
    output logic [3:0] count2Hi,
    output logic [3:0] count2Lo,
    output logic       snap_valid
);

    localparam logic [3:0] DB_MAX  = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] MIN_HI  = 4'(MIN_COUNT / 10);
    localparam logic [3:0] MIN_LO  = 4'(MIN_COUNT % 10);
    localparam logic [6:0] MIN_VAL = 7'(MIN_COUNT);

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (hi == 4'd9 && lo == 4'd9) begin
            return v;
        end
        if (lo == 4'd9) begin
            return {hi + 4'd1, 4'd0};
        end
        return {hi, lo + 4'd1};
    endfunction

    // Raise a BCD count to the MIN_COUNT floor, compared as a decimal value.
    function automatic logic [7:0] bcd_floor(input logic [7:0] v);
        logic [6:0] val;
        val = ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
        if (val < MIN_VAL) begin
            return {MIN_HI, MIN_LO};
        end
        return v;
    endfunction

    logic [1:0]      raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0][3:0] db_cnt_q;
    logic [1:0][3:0] db_cnt_d;
    logic [1:0]      deb_q;
    logic [1:0]      deb_d;
    logic [1:0]      deb_dly_q;
    logic [1:0]      evt_q;
    logic [1:0]      evt_d;
    logic [1:0][7:0] live_q;
    logic [1:0][7:0] live_d;
    logic [1:0][7:0] snap_q;
    logic [1:0][7:0] snap_d;
    logic            phase_q;
    logic            armed_q;
    logic            snap_valid_q;
    logic            phase_edge;

    assign raw        = {sensor2, sensor1};
    assign phase_edge = armed_q & (phase ^ phase_q);

    // Next-state for debounce, car events, live counters and snapshots.
    always_comb begin
        db_cnt_d = db_cnt_q;
        deb_d    = deb_q;
        evt_d    = evt_q;
        live_d   = live_q;
        snap_d   = snap_q;
        for (int r = 0; r < 2; r++) begin
            if (!sync2_q[r]) begin
                db_cnt_d[r] = 4'd0;
            end else if (db_cnt_q[r] != DB_MAX) begin
                db_cnt_d[r] = db_cnt_q[r] + 4'd1;
            end
            // Level rises in the same cycle the counter reaches the threshold,
            // so a pulse held for exactly DEBOUNCE_CYCLES samples is accepted.
            deb_d[r] = sync2_q[r] & (db_cnt_d[r] == DB_MAX);
            evt_d[r] = deb_q[r] & ~deb_dly_q[r];
            if (phase_edge) begin
                // A car arriving on the edge starts the new window.
                live_d[r] = evt_q[r] ? 8'h01 : 8'h00;
                snap_d[r] = bcd_floor(live_q[r]);
            end else if (evt_q[r]) begin
                live_d[r] = bcd_inc(live_q[r]);
            end
        end
    end

    // Phase history; holds no count state so it simply tracks the input.
    always_ff @(posedge clock) begin
        phase_q <= phase;
    end

    // Registered state with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            db_cnt_q     <= '0;
            deb_q        <= 2'b00;
            deb_dly_q    <= 2'b00;
            evt_q        <= 2'b00;
            live_q       <= '0;
            snap_q       <= '0;
            armed_q      <= 1'b0;
            snap_valid_q <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            deb_q        <= deb_d;
            deb_dly_q    <= deb_q;
            evt_q        <= evt_d;
            live_q       <= live_d;
            snap_q       <= snap_d;
            armed_q      <= 1'b1;
            snap_valid_q <= phase_edge;
        end
    end

    assign count1Hi   = snap_q[0][7:4];
    assign count1Lo   = snap_q[0][3:0];
    assign count2Hi   = snap_q[1][7:4];
    assign count2Lo   = snap_q[1][3:0];
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_vehicle_counter.sv
// tb_vehicle_counter: directed vector table plus hand-written corner cases
// and a randomised window sequence for vehicle_counter.
module tb_vehicle_counter;

    localparam int D   = 4;
    localparam int MIN = 1;

    logic       clock;
    logic       rst_n;
    logic       sensor1;
    logic       sensor2;
    logic       phase;
    logic [3:0] count1Hi;
    logic [3:0] count1Lo;
    logic [3:0] count2Hi;
    logic [3:0] count2Lo;
    logic       snap_valid;

    int compared;
    int mismatched;
    bit mon_en;

    vehicle_counter #(.DEBOUNCE_CYCLES(D), .MIN_COUNT(MIN)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .sensor1    (sensor1),
        .sensor2    (sensor2),
        .phase      (phase),
        .count1Hi   (count1Hi),
        .count1Lo   (count1Lo),
        .count2Hi   (count2Hi),
        .count2Lo   (count2Lo),
        .snap_valid (snap_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int n1;
        int l1;
        int n2;
        int l2;
        int e1;
        int e2;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int expect_cnt(input int cars);
        int v;
        v = (cars > 99) ? 99 : cars;
        return (v < MIN) ? MIN : v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic car(input int road, input int len, input int gap);
        if (road == 1) sensor1 = 1'b1; else sensor2 = 1'b1;
        repeat (len) tick();
        if (road == 1) sensor1 = 1'b0; else sensor2 = 1'b0;
        repeat (gap) tick();
    endtask

    // Toggle phase and check the snapshot one cycle later and the pulse width.
    task automatic snap(input string name, input int e1, input int e2);
        phase = ~phase;
        tick();
        chk({name, "_valid"}, 32'(snap_valid), 32'd1);
        chk({name, "_cnt1"}, {24'd0, count1Hi, count1Lo}, {24'd0, to_bcd(e1)});
        chk({name, "_cnt2"}, {24'd0, count2Hi, count2Lo}, {24'd0, to_bcd(e2)});
        tick();
        chk({name, "_valid_off"}, 32'(snap_valid), 32'd0);
    endtask

    task automatic road_rand(input int road, output int counted);
        int n;
        int len;
        counted = 0;
        n = int'($urandom_range(0, 6));
        for (int i = 0; i < n; i++) begin
            len = int'($urandom_range(1, 12));
            if (len >= D) counted++;
            car(road, len, int'($urandom_range(2, 5)));
        end
    endtask

    initial begin : main
        logic [15:0] prev;
        int c1;
        int c2;
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        sensor1    = 1'b0;
        sensor2    = 1'b0;
        phase      = 1'b1;

        vecs[0] = '{3, 10, 5, 10, 3, 5};
        vecs[1] = '{1, 2, 0, 10, 1, 1};
        vecs[2] = '{1, 3, 2, 4, 1, 2};
        vecs[3] = '{9, 10, 0, 10, 9, 1};
        vecs[4] = '{10, 10, 1, 5, 10, 1};
        vecs[5] = '{120, 6, 0, 10, 99, 1};
        vecs[6] = '{0, 10, 100, 4, 1, 99};

        // Monitor: digits always BCD, outputs change only with snap_valid.
        fork
            begin
                prev = '0;
                forever begin
                    @(negedge clock);
                    if (mon_en) begin
                        chk("bcd_digits", 32'(count1Hi <= 9 && count1Lo <= 9 &&
                                              count2Hi <= 9 && count2Lo <= 9), 32'd1);
                        chk("hold", 32'(snap_valid ||
                                        ({count1Hi, count1Lo, count2Hi, count2Lo} == prev)), 32'd1);
                    end
                    prev = {count1Hi, count1Lo, count2Hi, count2Lo};
                end
            end
        join_none

        // Reset with phase high, then quiet period.
        repeat (3) tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("reset_counts", {16'd0, count1Hi, count1Lo, count2Hi, count2Lo}, 32'd0);
            chk("reset_valid", 32'(snap_valid), 32'd0);
            tick();
        end

        // Vector table.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].n1; i++) car(1, vecs[v].l1, 8);
            for (int i = 0; i < vecs[v].n2; i++) car(2, vecs[v].l2, 8);
            snap($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2);
        end

        // Sensor-2 event coincident with the phase edge.
        car(2, 10, 8);
        car(2, 10, 8);
        sensor2 = 1'b1;
        repeat (7) tick();
        snap("coinc", 1, 2);
        sensor2 = 1'b0;
        repeat (8) tick();
        car(2, 10, 8);
        snap("after_coinc", 1, 2);

        // Reset in the middle of a window.
        for (int i = 0; i < 4; i++) car(1, 10, 8);
        car(2, 10, 8);
        car(2, 10, 8);
        snap("pre_reset", 4, 2);
        car(1, 10, 8);
        car(1, 10, 8);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        tick();
        chk("midreset_counts", {16'd0, count1Hi, count1Lo, count2Hi, count2Lo}, 32'd0);
        chk("midreset_valid", 32'(snap_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        chk("postreset_counts", {16'd0, count1Hi, count1Lo, count2Hi, count2Lo}, 32'd0);
        car(1, 10, 8);
        car(1, 10, 8);
        snap("post_reset", 2, 1);

        // Random windows with both roads active concurrently.
        for (int w = 0; w < 10; w++) begin
            fork
                road_rand(1, c1);
                road_rand(2, c2);
            join
            repeat (7) tick();
            snap($sformatf("rand%0d", w), expect_cnt(c1), expect_cnt(c2));
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
